// File: rtl/load_use_stall_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, bubble/pass select
// encoding and the bundled write-enable vector driven into the pipeline registers.
package load_use_stall_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 4;
  localparam int LAT_W          = 4;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STALL  = 2'd1;
  localparam logic [1:0] ST_FREEZE = 2'd2;

  localparam logic CTRL_BUBBLE = 1'b0;
  localparam logic CTRL_PASS   = 1'b1;

  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexWrite;
    logic exmemWrite;
    logic ctrlSel;
  } pipeCtrlT;

  localparam pipeCtrlT CTRL_OFF    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTRL_BUBBLE};
  localparam pipeCtrlT CTRL_FROZEN = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTRL_PASS};
  localparam pipeCtrlT CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, CTRL_BUBBLE};
  localparam pipeCtrlT CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, CTRL_BUBBLE};
  localparam pipeCtrlT CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, CTRL_PASS};

endpackage

// File: rtl/load_use_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/load_use_stall_ctrl.sv
// Load-use hazard controller: holds the front end for LOAD_LAT cycles per hazard,
// freezes the pipeline on memory busy, handles branch flush and counts stall cycles.
module load_use_stall_ctrl
  import load_use_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  mem_busy,
  input  logic                  flush,
  input  logic                  cnt_clr,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  exmem_write,
  output logic                  ctrl_sel,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOAD_LAT - 1);

  logic [1:0]       stateQ, stateD;
  logic [1:0]       retQ, retD;
  logic [1:0]       effState;
  logic [LAT_W-1:0] latQ, latD;
  logic             rs1Hit, rs2Hit, zeroMask, haz;
  logic             stallCyc;
  pipeCtrlT         ctrl;

  assign rs1Hit   = id_rs1_used && (idex_rd == id_rs1);
  assign rs2Hit   = id_rs2_used && (idex_rd == id_rs2);
  assign zeroMask = (ZERO_REG_EN != 0) && (idex_rd == '0);
  assign haz      = idex_mem_read && (rs1Hit || rs2Hit) && !zeroMask;

  // While frozen the machine behaves as the state it was frozen from once memory is ready.
  assign effState = (stateQ == ST_FREEZE) ? retQ : stateQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= ST_RUN;
      retQ   <= ST_RUN;
      latQ   <= '0;
    end else begin
      stateQ <= stateD;
      retQ   <= retD;
      latQ   <= latD;
    end
  end

  always_comb begin
    stateD = effState;
    retD   = retQ;
    latD   = latQ;
    if (mem_busy) begin
      stateD = ST_FREEZE;
      if (stateQ != ST_FREEZE) begin
        retD = stateQ;
      end
    end else if (flush) begin
      stateD = ST_RUN;
      latD   = '0;
    end else if (effState == ST_STALL) begin
      latD   = latQ - LAT_W'(1);
      stateD = (latQ == LAT_W'(1)) ? ST_RUN : ST_STALL;
    end else if (haz && (LOAD_LAT > 1)) begin
      stateD = ST_STALL;
      latD   = LAT_INIT;
    end else begin
      stateD = ST_RUN;
    end
  end

  always_comb begin
    ctrl     = CTRL_OFF;
    stallCyc = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        ctrl = CTRL_FROZEN;
      end else if (flush) begin
        ctrl = CTRL_FLUSH;
      end else if ((effState == ST_STALL) || haz) begin
        ctrl     = CTRL_STALL;
        stallCyc = 1'b1;
      end else begin
        ctrl = CTRL_NORMAL;
      end
    end
  end

  assign pc_write    = ctrl.pcWrite;
  assign ifid_write  = ctrl.ifidWrite;
  assign ifid_flush  = ctrl.ifidFlush;
  assign idex_write  = ctrl.idexWrite;
  assign exmem_write = ctrl.exmemWrite;
  assign ctrl_sel    = ctrl.ctrlSel;
  assign state       = stateQ;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stallCyc),
    .clr  (cnt_clr),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Bench for load_use_stall_ctrl: two instances (LOAD_LAT=1 with zero-reg masking,
// LOAD_LAT=3 without masking and a 4-bit counter) checked against a remaining-stall model.
module tb_load_use_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] id_rs1, id_rs2, idex_rd;
  logic       id_rs1_used, id_rs2_used, idex_mem_read, mem_busy, flush, cnt_clr;

  wire [5:0]  ctlA, ctlB;
  wire [1:0]  stA, stB;
  wire [15:0] cntA;
  wire [3:0]  cntB;

  logic [7:0]  obs    [2];
  logic [15:0] obsCnt [2];
  assign obs[0]    = {ctlA, stA};
  assign obs[1]    = {ctlB, stB};
  assign obsCnt[0] = cntA;
  assign obsCnt[1] = {12'd0, cntB};

  int nCmp = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  load_use_stall_ctrl #(.REG_ADDR_W(4), .LOAD_LAT(1), .ZERO_REG_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .mem_busy(mem_busy),
    .flush(flush), .cnt_clr(cnt_clr),
    .pc_write(ctlA[5]), .ifid_write(ctlA[4]), .ifid_flush(ctlA[3]),
    .idex_write(ctlA[2]), .exmem_write(ctlA[1]), .ctrl_sel(ctlA[0]),
    .state(stA), .stall_cnt(cntA)
  );

  load_use_stall_ctrl #(.REG_ADDR_W(4), .LOAD_LAT(3), .ZERO_REG_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .mem_busy(mem_busy),
    .flush(flush), .cnt_clr(cnt_clr),
    .pc_write(ctlB[5]), .ifid_write(ctlB[4]), .ifid_flush(ctlB[3]),
    .idex_write(ctlB[2]), .exmem_write(ctlB[1]), .ctrl_sel(ctlB[0]),
    .state(stB), .stall_cnt(cntB)
  );

  // Reference model: remaining stall cycles, a frozen flag and a saturating count.
  localparam int LAT  [2] = '{1, 3};
  localparam int ZR   [2] = '{1, 0};
  localparam int CMAX [2] = '{65535, 15};
  int stallLeft [2];
  bit frozen    [2];
  int mCnt      [2];

  function automatic bit modelHaz(int d);
    bit hit;
    hit = (id_rs1_used && idex_rd == id_rs1) || (id_rs2_used && idex_rd == id_rs2);
    return idex_mem_read && hit && !(ZR[d] != 0 && idex_rd == 4'd0);
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_write, exmem_write, ctrl_sel, state}
  function automatic logic [7:0] expOut(int d);
    logic [1:0] st;
    st = frozen[d] ? 2'd2 : ((stallLeft[d] > 0) ? 2'd1 : 2'd0);
    if (!rst_n) return 8'h00;
    if (mem_busy) return {6'b000001, st};
    if (flush) return {6'b111110, st};
    if (stallLeft[d] > 0 || modelHaz(d)) return {6'b000110, st};
    return {6'b110111, st};
  endfunction

  task automatic modelStep();
    for (int d = 0; d < 2; d++) begin
      bit inc;
      inc = 1'b0;
      if (!rst_n) begin
        stallLeft[d] = 0;
        frozen[d]    = 1'b0;
        mCnt[d]      = 0;
        continue;
      end
      if (mem_busy) begin
        frozen[d] = 1'b1;
      end else begin
        frozen[d] = 1'b0;
        if (flush) begin
          stallLeft[d] = 0;
        end else if (stallLeft[d] > 0) begin
          stallLeft[d]--;
          inc = 1'b1;
        end else if (modelHaz(d)) begin
          stallLeft[d] = LAT[d] - 1;
          inc = 1'b1;
        end
      end
      if (cnt_clr) mCnt[d] = 0;
      else if (inc && mCnt[d] < CMAX[d]) mCnt[d]++;
    end
  endtask

  task automatic drive(input logic [3:0] rs1, input logic [3:0] rs2, input logic u1,
                       input logic u2, input logic mr, input logic [3:0] rd,
                       input logic busy, input logic fl, input logic clr);
    id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    idex_mem_read = mr; idex_rd = rd; mem_busy = busy; flush = fl; cnt_clr = clr;
  endtask

  task automatic idle(input logic clr);
    drive(4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, clr);
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    #1;
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if (obs[d] !== 8'h00 || obsCnt[d] !== 16'd0) begin
        nFail++;
        $display("FAIL reset dut%0d: got ctl/state=%b cnt=%0d, want 00000000 cnt=0", d, obs[d], obsCnt[d]);
      end
    end
    modelStep();
    advance();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    int pcLow [2] = '{0, 0};
    for (int c = 0; c < 7; c++) begin
      if (c == 1) drive(4'd5, 4'd9, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
      else idle(c == 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        nCmp++;
        if (obs[d] !== expOut(d) || obsCnt[d] !== 16'(mCnt[d])) begin
          nFail++;
          $display("FAIL load_use dut%0d c%0d: got %b cnt=%0d, want %b cnt=%0d", d, c, obs[d], obsCnt[d], expOut(d), mCnt[d]);
        end
        if (c > 0 && !obs[d][7]) pcLow[d]++;
      end
      advance();
    end
    nCmp++;
    if (pcLow[0] != 1 || pcLow[1] != 3 || cntA !== 16'd1 || cntB !== 4'd3) begin
      nFail++;
      $display("FAIL load_use_len: got pcLow=%0d/%0d cnt=%0d/%0d, want 1/3 cnt=1/3", pcLow[0], pcLow[1], cntA, cntB);
    end
  endtask

  task automatic test_zero_reg();
    int pcLow [2] = '{0, 0};
    for (int c = 0; c < 10; c++) begin
      if (c == 1) drive(4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      else if (c == 5) drive(4'd2, 4'd7, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
      else idle(c == 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        nCmp++;
        if (obs[d] !== expOut(d) || obsCnt[d] !== 16'(mCnt[d])) begin
          nFail++;
          $display("FAIL zero_reg dut%0d c%0d: got %b cnt=%0d, want %b cnt=%0d", d, c, obs[d], obsCnt[d], expOut(d), mCnt[d]);
        end
        if (c > 0 && !obs[d][7]) pcLow[d]++;
      end
      advance();
    end
    nCmp++;
    if (pcLow[0] != 0 || pcLow[1] != 3 || cntA !== 16'd0 || cntB !== 4'd3) begin
      nFail++;
      $display("FAIL zero_reg_len: got pcLow=%0d/%0d cnt=%0d/%0d, want 0/3 cnt=0/3", pcLow[0], pcLow[1], cntA, cntB);
    end
  endtask

  task automatic test_freeze();
    int frozenCyc = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) drive(4'd5, 4'd9, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
      else if (c == 2 || c == 3) drive(4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
      else idle(c == 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        nCmp++;
        if (obs[d] !== expOut(d) || obsCnt[d] !== 16'(mCnt[d])) begin
          nFail++;
          $display("FAIL freeze dut%0d c%0d: got %b cnt=%0d, want %b cnt=%0d", d, c, obs[d], obsCnt[d], expOut(d), mCnt[d]);
        end
      end
      if (ctlB[5:1] == 5'b00000 && ctlB[0]) frozenCyc++;
      if (c == 3) begin
        nCmp++;
        if (stB !== 2'd2) begin
          nFail++;
          $display("FAIL freeze_state: got state=%0d, want 2", stB);
        end
      end
      advance();
    end
    nCmp++;
    if (frozenCyc != 2 || cntB !== 4'd3 || cntA !== 16'd1) begin
      nFail++;
      $display("FAIL freeze_len: got frozen=%0d cnt=%0d/%0d, want frozen=2 cnt=1/3", frozenCyc, cntA, cntB);
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 7; c++) begin
      if (c == 1) drive(4'd5, 4'd9, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
      else if (c == 2) drive(4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
      else idle(c == 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        nCmp++;
        if (obs[d] !== expOut(d) || obsCnt[d] !== 16'(mCnt[d])) begin
          nFail++;
          $display("FAIL flush dut%0d c%0d: got %b cnt=%0d, want %b cnt=%0d", d, c, obs[d], obsCnt[d], expOut(d), mCnt[d]);
        end
      end
      if (c == 2) begin
        nCmp++;
        if (ctlB !== 6'b111110 || stB !== 2'd1) begin
          nFail++;
          $display("FAIL flush_out: got ctl=%b state=%0d, want 111110 state=1", ctlB, stB);
        end
      end
      if (c == 3) begin
        nCmp++;
        if (stB !== 2'd0 || cntB !== 4'd1 || ctlB !== 6'b110111) begin
          nFail++;
          $display("FAIL flush_after: got state=%0d cnt=%0d ctl=%b, want 0 1 110111", stB, cntB, ctlB);
        end
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 23; c++) begin
      if (c == 0) idle(1'b1);
      else if (c <= 21) drive(4'd6, 4'd9, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, c == 21);
      else idle(1'b0);
      #1;
      for (int d = 0; d < 2; d++) begin
        nCmp++;
        if (obs[d] !== expOut(d) || obsCnt[d] !== 16'(mCnt[d])) begin
          nFail++;
          $display("FAIL saturation dut%0d c%0d: got %b cnt=%0d, want %b cnt=%0d", d, c, obs[d], obsCnt[d], expOut(d), mCnt[d]);
        end
      end
      if (c == 21) begin
        nCmp++;
        if (cntB !== 4'hF || cntA !== 16'd20) begin
          nFail++;
          $display("FAIL sat_hold: got cnt=%0d/%0d, want 20/15", cntA, cntB);
        end
      end
      if (c == 22) begin
        nCmp++;
        if (cntB !== 4'd0 || cntA !== 16'd0) begin
          nFail++;
          $display("FAIL clr_wins: got cnt=%0d/%0d, want 0/0", cntA, cntB);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 6, 4'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 29) == 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        nCmp++;
        if (obs[d] !== expOut(d) || obsCnt[d] !== 16'(mCnt[d])) begin
          nFail++;
          $display("FAIL random dut%0d c%0d: got %b cnt=%0d, want %b cnt=%0d", d, c, obs[d], obsCnt[d], expOut(d), mCnt[d]);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_stall();
    idle(1'b0);
    advance();
    drive(4'd5, 4'd9, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    advance();
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    nCmp++;
    if (ctlA !== 6'd0 || ctlB !== 6'd0 || stA !== 2'd0 || stB !== 2'd0 || cntA !== 16'd0 || cntB !== 4'd0) begin
      nFail++;
      $display("FAIL reset_mid: got ctl=%b/%b state=%0d/%0d cnt=%0d/%0d, want all 0", ctlA, ctlB, stA, stB, cntA, cntB);
    end
    modelStep();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) drive(4'd5, 4'd9, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
      else idle(1'b0);
      #1;
      for (int d = 0; d < 2; d++) begin
        nCmp++;
        if (obs[d] !== expOut(d) || obsCnt[d] !== 16'(mCnt[d])) begin
          nFail++;
          $display("FAIL reset_resume dut%0d c%0d: got %b cnt=%0d, want %b cnt=%0d", d, c, obs[d], obsCnt[d], expOut(d), mCnt[d]);
        end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_freeze();
    test_flush();
    test_saturation();
    test_random();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
